// File: rtl/bch_chien_arbiter.sv
// Round-robin sharing of one Chien-search engine between NREQ decoder channels:
// captures the winner's sigma, routes the engine stream to it and reports corrected bits at job end.
module bch_chien_arbiter #(
  parameter int M    = 4,
  parameter int K    = 5,
  parameter int T    = 3,
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*M*(T+1)-1:0] req_sigma,
  output logic [NREQ-1:0]         req_grant,
  output logic [NREQ-1:0]         out_ready,
  output logic [NREQ-1:0]         out_valid,
  output logic                    out_err,
  input  logic [NREQ-1:0]         out_accepted,
  output logic [NREQ-1:0]         done,
  output logic [M-1:0]            err_count,
  output logic                    eng_start,
  output logic [M*(T+1)-1:0]      eng_sigma,
  output logic                    eng_accepted,
  input  logic                    eng_busy,
  input  logic                    eng_ready,
  input  logic                    eng_valid,
  input  logic                    eng_err
);

  localparam int SW = M * (T + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  generate
    if (NREQ < 2 || NREQ > 8 || K < 1 || T < 1 || M < 2) begin : g_param_check
      $error("bch_chien_arbiter: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   rr_nxt;
  logic [PW:0]     pick_sum;
  logic            pick_found;
  logic [2*NREQ-1:0] req_rot;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] pick_oh;
  logic            seen_valid;
  logic [M-1:0]    err_cnt;
  logic            err_inc;
  logic            job_end;

  // Rotate the request vector so bit 0 is the channel rr_ptr points at;
  // the first set bit of the rotated view is the round-robin winner.
  always_comb begin
    req_rot    = {req_valid, req_valid} >> rr_ptr;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (PW+1)'(k);
        if (pick_sum >= (PW+1)'(NREQ)) begin
          pick_sum = pick_sum - (PW+1)'(NREQ);
        end
        pick_idx = pick_sum[PW-1:0];
      end
    end
  end

  assign pick_oh  = NREQ'(1) << pick_idx;
  assign owner_oh = NREQ'(1) << owner;
  assign rr_nxt   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  assign err_inc = (state == RUN) && eng_valid && eng_err && eng_accepted;
  assign job_end = (state == RUN) && seen_valid && !eng_valid && !eng_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the stream routing, which is purely a decode of state and owner.
  always_comb begin
    state_nxt    = state;
    out_ready    = '0;
    out_valid    = '0;
    out_err      = 1'b0;
    eng_accepted = 1'b0;
    case (state)
      CLEAR: begin
        // A job orphaned by reset is drained by accepting everything it emits.
        eng_accepted = 1'b1;
        if (!eng_busy && !eng_valid) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (pick_found) begin
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = RUN;
      end
      RUN: begin
        out_ready    = eng_ready ? owner_oh : '0;
        out_valid    = eng_valid ? owner_oh : '0;
        out_err      = eng_err;
        eng_accepted = out_accepted[owner];
        if (job_end) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= '0;
      rr_ptr     <= '0;
      seen_valid <= 1'b0;
      err_cnt    <= '0;
      req_grant  <= '0;
      done       <= '0;
      eng_start  <= 1'b0;
      eng_sigma  <= '0;
      err_count  <= '0;
    end else begin
      req_grant <= '0;
      done      <= '0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner      <= pick_idx;
            eng_sigma  <= req_sigma[pick_idx*SW +: SW];
            req_grant  <= pick_oh;
            rr_ptr     <= rr_nxt;
            err_cnt    <= '0;
            seen_valid <= 1'b0;
          end
        end
        START: begin
          eng_start <= 1'b1;
        end
        RUN: begin
          if (eng_valid) begin
            seen_valid <= 1'b1;
          end
          if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
          end
          if (job_end) begin
            done      <= owner_oh;
            err_count <= err_cnt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
